// File: rtl/pipe_addsub_seg.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into NSEG segments
// of SEG bits, one segment per stage, with operands skewed and results deskewed.
module pipe_addsub_seg #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG = WIDTH / SEG;

   // Handshake: an operation is accepted on a rising edge with en=1 and in_valid=1
   // (rst=0); its result is presented exactly NSEG enabled edges later with
   // out_valid=1 for one enabled cycle. en=0 freezes every register.
   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int IW = WIDTH - k * SEG;  // operand bits not yet consumed
      localparam int RW = (k + 1) * SEG;    // result bits produced so far

      logic          v_in;
      logic          c_in;
      logic [IW-1:0] a_in;
      logic [IW-1:0] b_in;
      logic [SEG:0]  seg_s;
      logic [RW-1:0] r_d;
      logic          v_q;
      logic          c_q;
      logic [RW-1:0] r_q;

      assign seg_s = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, c_in};

      if (k == 0) begin : g_in
         // Subtraction is a + ~b + ~borrow_in.
         assign v_in = in_valid;
         assign c_in = sub ^ cin;
         assign a_in = a;
         assign b_in = sub ? ~b : b;
         assign r_d  = seg_s[SEG-1:0];
      end else begin : g_in
         assign v_in = g_stage[k-1].v_q;
         assign c_in = g_stage[k-1].c_q;
         assign a_in = g_stage[k-1].g_fwd.a_q;
         assign b_in = g_stage[k-1].g_fwd.b_q;
         assign r_d  = {seg_s[SEG-1:0], g_stage[k-1].r_q};
      end

      // Data registers only move with a valid operation, so the final stage
      // naturally holds the last result across bubbles.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            r_q <= '0;
         end else if (en) begin
            v_q <= v_in;
            if (v_in) begin
               c_q <= seg_s[SEG];
               r_q <= r_d;
            end
         end
      end

      if (k < NSEG - 1) begin : g_fwd
         // Unconsumed upper segments travel with the operation.
         logic [IW-SEG-1:0] a_q;
         logic [IW-SEG-1:0] b_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en && v_in) begin
               a_q <= a_in[IW-1:SEG];
               b_q <= b_in[IW-1:SEG];
            end
         end
      end else begin : g_last
         logic ovf_q;

         // Carry into the MSB is recovered from the MSB sum bit and its operands.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (en && v_in) begin
               ovf_q <= a_in[SEG-1] ^ b_in[SEG-1] ^ seg_s[SEG-1] ^ seg_s[SEG];
            end
         end
      end
   end

   assign out_valid = g_stage[NSEG-1].v_q;
   assign sum       = g_stage[NSEG-1].r_q;
   assign cout      = g_stage[NSEG-1].c_q;
   assign ovf       = g_stage[NSEG-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_addsub_seg.sv
// Bench for pipe_addsub_seg: three instances (32/8, 8/2, 16/16) share one stimulus
// stream; a per-instance valid pipeline and result queue model every cycle.
module tb_pipe_addsub_seg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        in_valid = 1'b0;
   logic        sub = 1'b0;
   logic        cin = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;

   logic        ov0, co0, of0;
   logic [31:0] sum0;
   logic        ov1, co1, of1;
   logic [7:0]  sum1;
   logic        ov2, co2, of2;
   logic [15:0] sum2;

   always #5 clk = ~clk;

   pipe_addsub_seg #(.WIDTH(32), .SEG(8)) dut0 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub), .cin(cin),
      .a(a), .b(b), .out_valid(ov0), .sum(sum0), .cout(co0), .ovf(of0));

   pipe_addsub_seg #(.WIDTH(8), .SEG(2)) dut1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub), .cin(cin),
      .a(a[7:0]), .b(b[7:0]), .out_valid(ov1), .sum(sum1), .cout(co1), .ovf(of1));

   pipe_addsub_seg #(.WIDTH(16), .SEG(16)) dut2 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .sub(sub), .cin(cin),
      .a(a[15:0]), .b(b[15:0]), .out_valid(ov2), .sum(sum2), .cout(co2), .ovf(of2));

   // Scoreboard state: {ovf, cout, sum zero-extended to 32}
   logic [33:0] exp_q0[$];
   logic [33:0] exp_q1[$];
   logic [33:0] exp_q2[$];
   logic [33:0] last0 = '0;
   logic [33:0] last1 = '0;
   logic [33:0] last2 = '0;
   logic [3:0]  vp0 = '0;
   logic [3:0]  vp1 = '0;
   logic        vp2 = 1'b0;

   int n_check = 0;
   int n_pass  = 0;

   typedef struct {
      logic        sub;
      logic        cin;
      logic [31:0] a;
      logic [31:0] b;
      logic [33:0] e32;
      logic [33:0] e8;
      logic [33:0] e16;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_check++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [33:0] model(input int w, input logic [31:0] av,
                                         input logic [31:0] bv, input logic s,
                                         input logic c);
      logic [32:0] m, bb, full, low;
      logic        c0, co, cmsb;
      m    = (33'd1 << w) - 33'd1;
      bb   = {1'b0, (s ? ~bv : bv)} & m;
      c0   = s ^ c;
      full = ({1'b0, av} & m) + bb + {32'd0, c0};
      low  = ({1'b0, av} & (m >> 1)) + (bb & (m >> 1)) + {32'd0, c0};
      co   = full[w];
      cmsb = low[w-1];
      return {cmsb ^ co, co, full[31:0] & m[31:0]};
   endfunction

   // One clock: update the model with what the DUTs sample, then check 1 ns later.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
         vp0 = '0; vp1 = '0; vp2 = 1'b0;
         last0 = '0; last1 = '0; last2 = '0;
      end else if (en) begin
         if (in_valid) begin
            exp_q0.push_back(model(32, a, b, sub, cin));
            exp_q1.push_back(model(8, a, b, sub, cin));
            exp_q2.push_back(model(16, a, b, sub, cin));
         end
         vp0 = {vp0[2:0], in_valid};
         vp1 = {vp1[2:0], in_valid};
         vp2 = in_valid;
         if (vp0[3] && exp_q0.size() > 0) last0 = exp_q0.pop_front();
         if (vp1[3] && exp_q1.size() > 0) last1 = exp_q1.pop_front();
         if (vp2 && exp_q2.size() > 0) last2 = exp_q2.pop_front();
      end
      #1;
      chk("w32_valid", {33'd0, ov0}, {33'd0, vp0[3]});
      chk("w32_result", {of0, co0, sum0}, last0);
      chk("w8_valid", {33'd0, ov1}, {33'd0, vp1[3]});
      chk("w8_result", {of1, co1, 24'd0, sum1}, last1);
      chk("w16_valid", {33'd0, ov2}, {33'd0, vp2});
      chk("w16_result", {of2, co2, 16'd0, sum2}, last2);
   endtask

   task automatic drive_rand(input logic v);
      in_valid = v;
      sub      = 1'($urandom_range(0, 1));
      cin      = 1'($urandom_range(0, 1));
      a        = $urandom;
      b        = $urandom;
   endtask

   logic [34:0] snap;

   initial begin
      //          sub   cin   a             b              {ovf,cout,sum} 32 / 8 / 16
      vecs[0] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, {2'b01, 32'h00000000}, {2'b01, 32'h00}, {2'b01, 32'h0000}};
      vecs[1] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, {2'b10, 32'h80000000}, {2'b01, 32'h00}, {2'b01, 32'h0000}};
      vecs[2] = '{1'b0, 1'b1, 32'h00FFFFFF, 32'h00000000, {2'b00, 32'h01000000}, {2'b01, 32'h00}, {2'b01, 32'h0000}};
      vecs[3] = '{1'b1, 1'b0, 32'h00000005, 32'h00000007, {2'b00, 32'hFFFFFFFE}, {2'b00, 32'hFE}, {2'b00, 32'hFFFE}};
      vecs[4] = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, {2'b11, 32'h7FFFFFFF}, {2'b00, 32'hFF}, {2'b00, 32'hFFFF}};
      vecs[5] = '{1'b1, 1'b1, 32'h0000000A, 32'h00000003, {2'b01, 32'h00000006}, {2'b01, 32'h06}, {2'b01, 32'h0006}};
      vecs[6] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, {2'b11, 32'h00000000}, {2'b00, 32'h00}, {2'b00, 32'h0000}};
      vecs[7] = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, {2'b01, 32'h00000000}, {2'b01, 32'h00}, {2'b01, 32'h0000}};
      vecs[8] = '{1'b0, 1'b0, 32'h00004070, 32'h00004010, {2'b00, 32'h00008080}, {2'b10, 32'h80}, {2'b10, 32'h8080}};

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("reset_outputs", {of0, co0, sum0}, 34'd0);
      chk("reset_valid", {31'd0, ov0, ov1, ov2}, 34'd0);

      // Directed table: each op issued alone, checked 4 enabled cycles later
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         sub = vecs[i].sub;
         cin = vecs[i].cin;
         a   = vecs[i].a;
         b   = vecs[i].b;
         tick();
         in_valid = 1'b0;
         tick();
         tick();
         tick();
         chk("tbl_w32_valid", {33'd0, ov0}, 34'd1);
         chk("tbl_w32", {of0, co0, sum0}, vecs[i].e32);
         chk("tbl_w8", {of1, co1, 24'd0, sum1}, vecs[i].e8);
         chk("tbl_w16", {of2, co2, 16'd0, sum2}, vecs[i].e16);
      end

      // Random stream with bubbles
      for (int i = 0; i < 64; i++) begin
         drive_rand($urandom_range(0, 3) != 0);
         tick();
      end

      // Back-to-back stream with a 3-cycle stall while in_valid stays high
      for (int i = 0; i < 12; i++) begin
         drive_rand(1'b1);
         if (i == 6) begin
            snap = {ov0, of0, co0, sum0};
            en = 1'b0;
            for (int j = 0; j < 3; j++) begin
               drive_rand(1'b1);
               tick();
               chk("stall_hold", {1'b0, ov0, of0, co0, sum0}, {1'b0, snap});
            end
            en = 1'b1;
            drive_rand(1'b1);
         end
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("drain_empty", 34'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 34'd0);

      // Reset discards in-flight operations
      for (int i = 0; i < 3; i++) begin
         drive_rand(1'b1);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_flush_w32", {ov0, of0, co0, sum0}, 34'd0);
      chk("rst_flush_w8", {25'd0, ov1, of1, co1, sum1}, 34'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rst_no_emerge", {31'd0, ov0, ov1, ov2}, 34'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
